// File: rtl/fp_add_pkg.sv
// Shared widths, limits and types for the FP32 adder normalise stage.
package fp_add_pkg;

    localparam int MENT_WIDTH = 23;
    localparam int EXPO_WIDTH = 8;
    localparam int POS_W      = $clog2(MENT_WIDTH) + 1;
    localparam int EXP_MAX    = (1 << EXPO_WIDTH) - 1;
    localparam int SUM_W      = MENT_WIDTH + 2;
    localparam int EXPN_W     = EXPO_WIDTH + 2;
    localparam int RES_W      = 1 + EXPO_WIDTH + MENT_WIDTH;

    typedef enum logic [1:0] {
        ZERO,
        CARRY,
        LEFT
    } norm_class_t;

    typedef struct packed {
        logic [RES_W-1:0] word;
        logic             ovf;
        logic             unf;
    } norm_out_t;

endpackage

// File: rtl/fp_add_normalize_stage_if.sv
// Upstream/downstream handshake bundle of the normalise stage.
interface fp_add_normalize_stage_if;
    import fp_add_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  sign_in;
    logic [EXPO_WIDTH-1:0] exp_in;
    logic [SUM_W-1:0]      sum_in;
    logic [POS_W-1:0]      normalize_position_in;
    logic                  position_valid_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [RES_W-1:0]      result_out;
    logic                  overflow_out;
    logic                  underflow_out;

    // Producer/consumer side (drives beats, accepts results)
    modport master (
        output in_valid, sign_in, exp_in, sum_in, normalize_position_in,
               position_valid_in, out_ready,
        input  in_ready, out_valid, result_out, overflow_out, underflow_out
    );

    // Stage side
    modport slave (
        input  in_valid, sign_in, exp_in, sum_in, normalize_position_in,
               position_valid_in, out_ready,
        output in_ready, out_valid, result_out, overflow_out, underflow_out
    );

endinterface

// File: rtl/fp_norm_shifter.sv
// Combinational barrel shifter: right by sh when rshift, else left by sh; keeps low OUT_W bits.
module fp_norm_shifter #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 23,
    parameter int SH_W  = 6
) (
    input  logic [IN_W-1:0]  din,
    input  logic [SH_W-1:0]  sh,
    input  logic             rshift,
    output logic [OUT_W-1:0] dout
);

    assign dout = OUT_W'(rshift ? (din >> sh) : (din << sh));

endmodule

// File: rtl/fp_add_normalize_stage.sv
// FP32 adder stage 4: normalise the mantissa sum and pack the IEEE-754 word.
// S1 classifies and computes the exponent, S2 shifts and applies overflow/underflow.
module fp_add_normalize_stage
    import fp_add_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    fp_add_normalize_stage_if.slave bus
);

    localparam logic signed [EXPN_W-1:0] EXPN_MAX  = EXPN_W'(EXP_MAX);
    localparam logic signed [EXPN_W-1:0] EXPN_ZERO = '0;

    // Saturate to infinity on exponent overflow, flush to +0 on underflow
    function automatic norm_out_t saturate_pack(
        input logic                     sign,
        input norm_class_t              cls,
        input logic signed [EXPN_W-1:0] exp_n,
        input logic                     inf_in,
        input logic [MENT_WIDTH-1:0]    mant
    );
        norm_out_t r;
        r.word = {sign, exp_n[EXPO_WIDTH-1:0], mant};
        r.ovf  = 1'b0;
        r.unf  = 1'b0;
        case (cls)
            CARRY, LEFT: begin
                if (inf_in || exp_n >= EXPN_MAX) begin
                    r.word = {sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
                    r.ovf  = 1'b1;
                end else if (exp_n <= EXPN_ZERO) begin
                    r.word = '0;
                    r.unf  = 1'b1;
                end
            end
            default: r.word = '0;
        endcase
        return r;
    endfunction

    logic                     adv2;
    logic                     accept;

    norm_class_t              cls_p0;
    logic [POS_W-1:0]         shift_p0;
    logic signed [EXPN_W-1:0] exp_p0;

    logic                     vld_p1;
    logic                     sign_p1;
    norm_class_t              cls_p1;
    logic [POS_W-1:0]         shift_p1;
    logic signed [EXPN_W-1:0] exp_p1;
    logic [SUM_W-1:0]         sum_p1;
    logic                     inf_p1;
    logic [MENT_WIDTH-1:0]    mant_p1;
    norm_out_t                pack_p1;

    logic                     vld_p2;
    norm_out_t                out_p2;

    assign adv2         = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || adv2;
    assign accept       = bus.in_valid && bus.in_ready;

    // ---- S0: classify the incoming sum and derive shift/exponent ----
    always_comb begin
        cls_p0   = LEFT;
        shift_p0 = POS_W'(MENT_WIDTH) - bus.normalize_position_in;
        exp_p0   = $signed({2'b00, bus.exp_in})
                 - $signed({{(EXPN_W-POS_W){1'b0}}, shift_p0});
        if (!bus.sum_in[SUM_W-1] && !bus.position_valid_in) begin
            cls_p0   = ZERO;
            shift_p0 = '0;
            exp_p0   = '0;
        end else if (bus.sum_in[SUM_W-1]) begin
            cls_p0   = CARRY;
            shift_p0 = POS_W'(1);
            exp_p0   = $signed({2'b00, bus.exp_in}) + EXPN_W'(1);
        end
    end

    // ---- S1: valid bit advances whenever the stage can take a beat ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    // S1 data captured only on an accepted beat
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p1  <= bus.sign_in && (cls_p0 != ZERO);
            cls_p1   <= cls_p0;
            shift_p1 <= shift_p0;
            exp_p1   <= exp_p0;
            sum_p1   <= bus.sum_in;
            inf_p1   <= &bus.exp_in;
        end
    end

    fp_norm_shifter #(
        .IN_W  (SUM_W),
        .OUT_W (MENT_WIDTH),
        .SH_W  (POS_W)
    ) u_shifter (
        .din    (sum_p1),
        .sh     (shift_p1),
        .rshift (cls_p1 == CARRY),
        .dout   (mant_p1)
    );

    assign pack_p1 = saturate_pack(sign_p1, cls_p1, exp_p1, inf_p1, mant_p1);

    // ---- S2: output register, held while downstream stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_p2 <= pack_p1;
            end
        end
    end

    assign bus.out_valid     = vld_p2;
    assign bus.result_out    = out_p2.word;
    assign bus.overflow_out  = out_p2.ovf;
    assign bus.underflow_out = out_p2.unf;

endmodule
